// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mul_arb_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_arb_mul_core.sv
// Purely combinational unsigned W x W multiplier with a full 2*W-bit product.
module mul_core
  import mul_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] z_o
);

  // Zero-extend both operands so the product is formed at full width.
  assign z_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule

// File: rtl/mul_arb.sv
// Two-requester round-robin arbiter in front of a shared multiplier, with a
// single-entry response register and a wrapping completion counter.
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_z,
  output logic [7:0]     done_cnt
);

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           id_q, id_d;
  logic [2*W-1:0] z_q, z_d;
  logic [7:0]     done_q, done_d;
  logic           grant;
  logic           accept;
  logic [2*W-1:0] prod;

  mul_core #(.W(W)) u_mul_core (
    .a_i (a_q),
    .b_i (b_q),
    .z_o (prod)
  );

  // On a tie the requester that did not win last time gets the grant.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign rsp_valid = (state_q == RSP);
  assign rsp_id    = id_q;
  assign rsp_z     = z_q;
  assign done_cnt  = done_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    z_d          = z_q;
    done_d       = done_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = MUL;
        end
      end
      MUL: begin
        z_d     = prod;
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          done_d  = done_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      z_q          <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      z_q          <= z_d;
      done_q       <= done_d;
    end
  end

endmodule
